// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, display-register struct and leading-zero helper for seg7_scan_driver.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
    } disp_t;

    localparam disp_t DISP_RST = '{value: 16'h0000, dp: 4'h0, lzb: 1'b0};

    // Digit idx is blanked when blanking is on and it and every digit to its left are zero.
    function automatic logic lzb_blank(input disp_t d, input logic [1:0] idx);
        logic b;
        case (idx)
            2'd1:    b = d.lzb & (d.value[15:4] == 12'h000);
            2'd2:    b = d.lzb & (d.value[15:8] == 8'h00);
            2'd3:    b = d.lzb & (d.value[15:12] == 4'h0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/strobe inputs and display pin outputs of the 4-digit scanner.
interface seg7_scan_driver_if;

    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        lzb_i;
    logic        load_i;
    logic        blink_i;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic        pending_o;
    logic        frame_o;

    modport slave (
        input  value_i, dp_i, lzb_i, load_i, blink_i,
        output seg_o, an_o, pending_o, frame_o
    );

    modport master (
        output value_i, dp_i, lzb_i, load_i, blink_i,
        input  seg_o, an_o, pending_o, frame_o
    );

endinterface

// File: rtl/seg7_scan_driver_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder; bit 7 (DP) is returned off.
module hex7seg (
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    // Active-low patterns, bits 6:0 = g..a.
    always_comb begin
        o_seg = 8'hFF;
        case (i_nib)
            4'h0:    o_seg = 8'hC0;
            4'h1:    o_seg = 8'hF9;
            4'h2:    o_seg = 8'hA4;
            4'h3:    o_seg = 8'hB0;
            4'h4:    o_seg = 8'h99;
            4'h5:    o_seg = 8'h92;
            4'h6:    o_seg = 8'h82;
            4'h7:    o_seg = 8'hF8;
            4'h8:    o_seg = 8'h80;
            4'h9:    o_seg = 8'h90;
            4'hA:    o_seg = 8'h88;
            4'hB:    o_seg = 8'h83;
            4'hC:    o_seg = 8'hC6;
            4'hD:    o_seg = 8'hA1;
            4'hE:    o_seg = 8'h86;
            4'hF:    o_seg = 8'h8E;
            default: o_seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode scanner with tear-free frame updates.
// Optional whole-display blink is compiled in with macro SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int GHOST_CYC    = 4,
    parameter int BLINK_FRAMES = 62
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int            CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GH_END = CW'(GHOST_CYC);

    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [1:0]            r_idx, w_idx_nxt;
    disp_t                 r_shadow, r_disp, w_disp_nxt, w_in;
    logic                  r_pend, r_frame;
    logic [7:0]            r_seg, w_seg_nxt, w_dec;
    logic [NUM_DIGITS-1:0] r_an, w_an_nxt, w_an_sel;
    logic [3:0]            w_nib;
    logic                  w_tc, w_bound, w_blank, w_blink_off;

    assign w_in    = {bus.value_i, bus.dp_i, bus.lzb_i};
    assign w_tc    = (r_cnt == CNT_TC);
    assign w_bound = w_tc & (r_idx == 2'd3);

    // Next slot position and next display word; outputs are built from these so they line up with frame_o.
    always_comb begin
        w_cnt_nxt  = r_cnt + CW'(1);
        w_idx_nxt  = r_idx;
        w_disp_nxt = r_disp;
        if (w_tc) begin
            w_cnt_nxt = {CW{1'b0}};
            w_idx_nxt = r_idx + 2'd1;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
        if (w_bound) begin
            w_disp_nxt = bus.load_i ? w_in : r_shadow;
        end else begin
            w_disp_nxt = r_disp;
        end
    end

    // Nibble of the digit that will be scanned next cycle.
    always_comb begin
        w_nib    = 4'h0;
        w_an_sel = AN_OFF;
        case (w_idx_nxt)
            2'd0:    begin w_nib = w_disp_nxt.value[3:0];   w_an_sel = 4'b1110; end
            2'd1:    begin w_nib = w_disp_nxt.value[7:4];   w_an_sel = 4'b1101; end
            2'd2:    begin w_nib = w_disp_nxt.value[11:8];  w_an_sel = 4'b1011; end
            2'd3:    begin w_nib = w_disp_nxt.value[15:12]; w_an_sel = 4'b0111; end
            default: begin w_nib = 4'h0;                    w_an_sel = AN_OFF;  end
        endcase
    end

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

`ifdef SEG7_BLINK_EN
    localparam int            BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_phase_on, w_phase_nxt;

    // Frame counter toggles the blink phase; dropping blink_i restarts it in the lit phase.
    always_comb begin
        w_bcnt_nxt  = r_bcnt;
        w_phase_nxt = r_phase_on;
        if (!bus.blink_i) begin
            w_bcnt_nxt  = {BW{1'b0}};
            w_phase_nxt = 1'b1;
        end else if (w_bound) begin
            if (r_bcnt == BLINK_TC) begin
                w_bcnt_nxt  = {BW{1'b0}};
                w_phase_nxt = ~r_phase_on;
            end else begin
                w_bcnt_nxt  = r_bcnt + BW'(1);
            end
        end else begin
            w_bcnt_nxt  = r_bcnt;
            w_phase_nxt = r_phase_on;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt     <= {BW{1'b0}};
            r_phase_on <= 1'b1;
        end else begin
            r_bcnt     <= w_bcnt_nxt;
            r_phase_on <= w_phase_nxt;
        end
    end

    assign w_blink_off = bus.blink_i & ~w_phase_nxt;
`else
    logic w_unused;
    assign w_unused    = bus.blink_i;
    assign w_blink_off = 1'b0;
`endif

    // Segment/anode values for next cycle, including blanking and the anti-ghost window.
    always_comb begin
        w_blank = lzb_blank(w_disp_nxt, w_idx_nxt);
        if (w_blank) begin
            w_seg_nxt = SEG_BLANK;
        end else begin
            w_seg_nxt = {~w_disp_nxt.dp[w_idx_nxt], w_dec[6:0]};
        end
        if ((w_cnt_nxt < GH_END) || w_blank || w_blink_off) begin
            w_an_nxt = AN_OFF;
        end else begin
            w_an_nxt = w_an_sel;
        end
    end

    // Scan counters, shadow/display words and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= {CW{1'b0}};
            r_idx    <= 2'd0;
            r_shadow <= DISP_RST;
            r_disp   <= DISP_RST;
            r_pend   <= 1'b0;
            r_frame  <= 1'b0;
            r_seg    <= SEG_BLANK;
            r_an     <= AN_OFF;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_disp  <= w_disp_nxt;
            r_frame <= w_bound;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
            if (bus.load_i) begin
                r_shadow <= w_in;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_bound) begin
                r_pend <= 1'b0;
            end else if (bus.load_i) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    assign bus.seg_o     = r_seg;
    assign bus.an_o      = r_an;
    assign bus.pending_o = r_pend;
    assign bus.frame_o   = r_frame;

endmodule
